// File: rtl/uart_param.sv
// uart_param: UART with TX/RX FIFOs; parity generation/checking only under `UART_PARITY_EN.
// Latency: start bit on the line 2 clk after tx_wr from idle; RX byte visible 1 clk after its stop sample.
// Backpressure: tx_wr dropped while tx_ready=0; a byte completing into a full RX FIFO is dropped and sets rx_overrun.

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_dat,
  input  logic         rd,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_rd, do_wr;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd  = rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_wr  = wr && (!full || do_rd);
  assign rd_dat = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_dat;
  end
endmodule

module uart_param #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_MODE     = 0,
  parameter int TX_FIFO_DEPTH   = 16,
  parameter int RX_FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 uart_tx_pin,
  input  logic                 uart_rx_pin,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 err_clr
);
  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [2:0]    DLAST   = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SLAST   = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD} state_t;

  state_t               tx_state, rx_state;
  logic [CW-1:0]        tx_cnt, rx_cnt;
  logic [2:0]           tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, tx_head, rx_sh;
  logic                 tx_full, tx_empty, tx_pop, tx_par;
  logic                 rx_full, rx_empty, rx_done, rx_s, rx_prev;
  logic [1:0]           rx_sync;
  logic                 frame_set, overrun_set;

  uart_fifo #(.W(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(tx_wr), .wr_dat(tx_data), .rd(tx_pop),
    .rd_dat(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.W(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(rx_done), .wr_dat(rx_sh), .rd(rx_rd),
    .rd_dat(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state != S_IDLE) || !tx_empty;
  assign rx_valid = !rx_empty;
  assign rx_s     = rx_sync[1];
  // The last stop bit hands straight over to the next queued byte, so frames run back to back.
  assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) ||
                    (tx_state == S_STOP && tx_cnt == LAST && tx_bit == SLAST));
  assign rx_done     = (rx_state == S_STOP) && (rx_cnt == LAST) && rx_s;
  assign frame_set   = (rx_state == S_STOP) && (rx_cnt == LAST) && !rx_s;
  assign overrun_set = rx_done && rx_full && !rx_rd;

`ifdef UART_PARITY_EN
  localparam bit PAR_ON  = (PARITY_MODE != 0);
  localparam bit PAR_ODD = (PARITY_MODE == 1);
  logic rx_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tx_par <= 1'b0;
    else if (tx_pop) tx_par <= (^tx_head) ^ PAR_ODD;
  end

  assign rx_par_bad = (rx_state == S_PARITY) && (rx_cnt == LAST) &&
                      (rx_s != ((^rx_sh) ^ PAR_ODD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rx_parity_err <= 1'b0;
    else if (rx_par_bad) rx_parity_err <= 1'b1;
    else if (err_clr)    rx_parity_err <= 1'b0;
  end
`else
  localparam bit PAR_ON = 1'b0;
  assign tx_par        = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_sh       <= '0;
      uart_tx_pin <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: if (!tx_empty) begin
          tx_sh       <= tx_head;
          tx_cnt      <= '0;
          uart_tx_pin <= 1'b0;
          tx_state    <= S_START;
        end
        S_START: if (tx_cnt == LAST) begin
          tx_cnt      <= '0;
          tx_bit      <= '0;
          uart_tx_pin <= tx_sh[0];
          tx_sh       <= tx_sh >> 1;
          tx_state    <= S_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        S_DATA: if (tx_cnt == LAST) begin
          tx_cnt <= '0;
          if (tx_bit != DLAST) begin
            uart_tx_pin <= tx_sh[0];
            tx_sh       <= tx_sh >> 1;
            tx_bit      <= tx_bit + 3'd1;
          end else if (PAR_ON) begin
            uart_tx_pin <= tx_par;
            tx_state    <= S_PARITY;
          end else begin
            uart_tx_pin <= 1'b1;
            tx_bit      <= '0;
            tx_state    <= S_STOP;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        S_PARITY: if (tx_cnt == LAST) begin
          tx_cnt      <= '0;
          tx_bit      <= '0;
          uart_tx_pin <= 1'b1;
          tx_state    <= S_STOP;
        end else tx_cnt <= tx_cnt + CW'(1);
        S_STOP: if (tx_cnt == LAST) begin
          tx_cnt <= '0;
          if (tx_bit != SLAST) tx_bit <= tx_bit + 3'd1;
          else if (!tx_empty) begin
            tx_sh       <= tx_head;
            uart_tx_pin <= 1'b0;
            tx_state    <= S_START;
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx_pin};
      rx_prev <= rx_s;
      case (rx_state)
        // The edge-detect cycle already counts towards the half-bit wait.
        S_IDLE: if (rx_prev && !rx_s) begin
          rx_cnt   <= CW'(1);
          rx_state <= S_START;
        end
        S_START: if (rx_cnt >= HALF_M1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_DATA: if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bit != DLAST) rx_bit <= rx_bit + 3'd1;
          else rx_state <= PAR_ON ? S_PARITY : S_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_PARITY: if (rx_cnt == LAST) begin
          rx_cnt   <= '0;
          rx_state <= S_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_STOP: if (rx_cnt == LAST) begin
          rx_cnt   <= '0;
          rx_state <= rx_s ? S_IDLE : S_HOLD;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_HOLD: if (rx_s) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (frame_set)    rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      if (overrun_set)  rx_overrun   <= 1'b1;
      else if (err_clr) rx_overrun   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at DIV=4, TX depth 4, RX depth 2; parity cases expect 8E1 when UART_PARITY_EN is set.
module tb_uart_param;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 11 : 10;

  logic       clk, rst_n, tx_wr, tx_ready, tx_busy, uart_tx_pin, rx_line;
  logic [7:0] tx_data, rx_data;
  logic       rx_rd, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, err_clr;
  logic       loop, rx_drv;
  int         compared, mismatched;

  assign rx_line = loop ? uart_tx_pin : rx_drv;

  uart_param #(
    .CLOCK_FREQUENCY(400), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
    .PARITY_MODE(2), .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .uart_tx_pin(uart_tx_pin),
    .uart_rx_pin(rx_line), .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h, need %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits at most lim negedges for the start bit; leaves us on its first cycle.
  task automatic wait_start(input string tag, input int lim);
    int k = 0;
    while (uart_tx_pin !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, uart_tx_pin, 0);
  endtask

  // Checks every cycle of one frame, starting on the first cycle of its start bit.
  task automatic check_frame(input logic [7:0] d);
    logic [10:0] e;
    e = PAR ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
    for (int b = 0; b < NB; b++) begin
      logic [3:0] seen;
      for (int c = 0; c < 4; c++) begin
        seen[c] = uart_tx_pin;
        @(negedge clk);
      end
      chk($sformatf("frame_%h_bit%0d", d, b), seen, {4{e[b]}});
    end
  endtask

  task automatic rx_bit(input logic v);
    rx_drv = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic flip_par, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (PAR) rx_bit((^d) ^ flip_par);
    rx_bit(stop);
    rx_drv = 1'b1;
  endtask

  task automatic pop;
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] bq [6];
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    compared = 0; mismatched = 0;
    rst_n = 1'b0; tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0; err_clr = 1'b0;
    loop = 1'b1; rx_drv = 1'b1;

    wait_n(2);
    chk("rst_tx_pin", uart_tx_pin, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    rst_n = 1'b1;
    wait_n(3);

    // Single byte from idle: start edge within 2 clk, exact bit pattern, looped into RX.
    tx_wr = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_start("a5_start_latency", 1);
    chk("a5_busy", tx_busy, 1);
    check_frame(8'hA5);
    chk("a5_line_idle", uart_tx_pin, 1);
    chk("a5_busy_done", tx_busy, 0);
    wait_n(10);
    chk("a5_rx_valid", rx_valid, 1);
    chk("a5_rx_data", rx_data, 8'hA5);
    pop;
    chk("a5_rx_popped", rx_valid, 0);

    // One byte in flight plus a 5-write burst into a depth-4 FIFO: last write dropped, no idle gaps.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_wr = 1'b1; tx_data = bq[i];
          if (i == 5) chk("burst_tx_ready_full", tx_ready, 0);
          @(negedge clk);
        end
        tx_wr = 1'b0;
        chk("burst_tx_ready_drop", tx_ready, 0);
      end
      begin
        wait_start("burst_start", 3);
        for (int i = 0; i < 5; i++) check_frame(bq[i]);
        chk("burst_no_sixth", uart_tx_pin, 1);
        chk("burst_busy_done", tx_busy, 0);
      end
    join

    // The looped burst overflowed the depth-2 RX FIFO.
    wait_n(10);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_head", rx_data, 8'h11);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_no_frame_err", rx_frame_err, 0);
    pulse_clr;
    chk("ovr_cleared", rx_overrun, 0);
    pop;
    chk("ovr_second", rx_data, 8'h22);
    pop;
    chk("ovr_drained", rx_valid, 0);
    pop;
    chk("rd_empty_noop", {rx_valid, rx_data}, 0);

    // Loopback with correct parity, then a hand-built frame with flipped parity.
    tx_wr = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_n(NB * 4 + 12);
    chk("par_ok_valid", rx_valid, 1);
    chk("par_ok_data", rx_data, 8'h3C);
    chk("par_ok_err", rx_parity_err, 0);
    pop;
    loop = 1'b0;
    rx_send(8'h3C, 1'b1, 1'b1);
    wait_n(6);
    chk("par_bad_err", rx_parity_err, PAR);
    chk("par_bad_valid", rx_valid, 1);
    chk("par_bad_data", rx_data, 8'h3C);
    pop;
    pulse_clr;
    chk("par_cleared", rx_parity_err, 0);

    // Short low glitch must be rejected.
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    wait_n(20);
    chk("glitch_no_push", rx_valid, 0);

    // Low stop bit: frame error, byte discarded; next good frame still lands.
    rx_send(8'h5A, 1'b0, 1'b0);
    wait_n(6);
    chk("ferr_flag", rx_frame_err, 1);
    chk("ferr_no_push", rx_valid, 0);
    rx_send(8'h77, 1'b0, 1'b1);
    wait_n(6);
    chk("after_ferr_data", {rx_valid, rx_data}, {1'b1, 8'h77});

    // Reset in the middle of a frame with another byte still queued.
    tx_wr = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_n(8);
    chk("pre_rst_line_low", uart_tx_pin, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_pin", uart_tx_pin, 1);
    chk("rst_mid_flags", {tx_busy, tx_ready, rx_valid, rx_frame_err}, 4'b0100);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(3);
    chk("post_rst_tx", {tx_busy, tx_ready, uart_tx_pin}, 3'b011);
    chk("post_rst_rx", {rx_valid, rx_data}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
